// File: rtl/keypad_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Scanner FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  // Number of keys held in an image: none, exactly one, or several
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ONE  = 2'd1,
    CLS_MANY = 2'd2
  } key_class_t;

  // Active-low one-hot column strobes
  localparam logic [NUM_COLS-1:0] COL0 = 4'b1110;
  localparam logic [NUM_COLS-1:0] COL1 = 4'b1101;
  localparam logic [NUM_COLS-1:0] COL2 = 4'b1011;
  localparam logic [NUM_COLS-1:0] COL3 = 4'b0111;

  // 0 / 1 / many classification; a single set bit is the only case where
  // clearing the lowest set bit leaves zero.
  function automatic key_class_t classify(input logic [NUM_KEYS-1:0] img);
    key_class_t cls;
    if (img == '0) begin
      cls = CLS_NONE;
    end else if ((img & (img - 16'd1)) == '0) begin
      cls = CLS_ONE;
    end else begin
      cls = CLS_MANY;
    end
    return cls;
  endfunction

  // Image bits are stored column-major (col*4 + row) while key codes are
  // row-major (row*4 + col), so the bit index has its two halves swapped.
  function automatic logic [3:0] bit_to_code(input logic [NUM_KEYS-1:0] img);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (img[i]) begin
        idx = 4'(i);
      end
    end
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the key event outputs toward the display path.
interface keypad_scanner_if;
  logic [3:0] row;        // active-low rows from the keypad
  logic [3:0] col;        // active-low one-hot column strobes
  logic [3:0] key_code;   // last accepted key, 4*row + col
  logic       key_valid;  // one-cycle pulse on a new accepted key
  logic       key_down;   // a debounced key is held
  logic       multi_key;  // more than one debounced key is held

  // Scanner side
  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_down,
    output multi_key
  );

  // Board / consumer side
  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  multi_key
  );
endinterface

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer: the debounced image only follows the snapshot once
// DEBOUNCE_SCANS consecutive completed scans have produced the same value.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] snapshot,
  input  logic                scan_done,
  output logic [NUM_KEYS-1:0] debounced
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [NUM_KEYS-1:0] prev_reg;
  logic [NUM_KEYS-1:0] debounced_reg;
  logic [CNT_W-1:0]    stable_cnt_reg;
  logic [CNT_W-1:0]    stable_cnt_next;

  // Count consecutive matches against the previous scan, saturating at CNT_MAX
  always_comb begin
    stable_cnt_next = '0;
    if (snapshot == prev_reg) begin
      stable_cnt_next = (stable_cnt_reg == CNT_MAX) ? stable_cnt_reg
                                                    : stable_cnt_reg + CNT_W'(1);
    end
  end

  // Update history on every completed scan; commit once the run is long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg       <= '0;
      stable_cnt_reg <= '0;
      debounced_reg  <= '0;
    end else if (scan_done) begin
      prev_reg       <= snapshot;
      stable_cnt_reg <= stable_cnt_next;
      if (stable_cnt_next == CNT_MAX) begin
        debounced_reg <= snapshot;
      end
    end
  end

  assign debounced = debounced_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating column strobe, row synchroniser,
// snapshot capture, whole-image debounce and single-key event FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    div_reg;
  logic [1:0]          col_idx_reg;
  logic [NUM_ROWS-1:0] row_meta_reg;
  logic [NUM_ROWS-1:0] row_sync_reg;
  logic [NUM_COLS-1:0] col_strobe;
  logic                sample;
  logic                scan_done;
  logic [NUM_ROWS-1:0] row_pressed;
  logic [NUM_ROWS-1:0] raw_nib [NUM_COLS-1];
  logic [NUM_KEYS-1:0] snapshot;
  logic [NUM_KEYS-1:0] debounced;
  key_class_t          key_class;

  state_t              state_reg;
  logic [3:0]          key_code_reg;
  logic                key_valid_reg;
  logic                key_down_reg;
  logic                multi_key_reg;

  // Column slot timer and column pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg     <= '0;
      col_idx_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg     <= '0;
      col_idx_reg <= col_idx_reg + 2'd1;
    end else begin
      div_reg     <= div_reg + DIV_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_reg <= '1;
      row_sync_reg <= '1;
    end else begin
      row_meta_reg <= kp.row;
      row_sync_reg <= row_meta_reg;
    end
  end

  // Decode the column pointer to the active-low strobe
  always_comb begin
    col_strobe = COL0;
    case (col_idx_reg)
      2'd0:    col_strobe = COL0;
      2'd1:    col_strobe = COL1;
      2'd2:    col_strobe = COL2;
      default: col_strobe = COL3;
    endcase
  end

  // Sample at the end of each column slot, giving the rows the whole slot to settle
  assign sample      = (div_reg == DIV_LAST);
  assign scan_done   = sample && (col_idx_reg == 2'd3);
  assign row_pressed = ~row_sync_reg;

  // Columns 0..2 are held in registers; column 3 is sampled in the same cycle
  // the snapshot completes, so it feeds the snapshot directly.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS - 1; gi++) begin : g_col
      logic [NUM_ROWS-1:0] nib_reg;

      // Capture this column's pressed rows on its sample cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          nib_reg <= '0;
        end else if (sample && (col_idx_reg == 2'(gi))) begin
          nib_reg <= row_pressed;
        end
      end

      assign raw_nib[gi] = nib_reg;
    end
  endgenerate

  assign snapshot = {row_pressed, raw_nib[2], raw_nib[1], raw_nib[0]};

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .snapshot  (snapshot),
    .scan_done (scan_done),
    .debounced (debounced)
  );

  assign key_class = classify(debounced);

  // Key event FSM: one pulse per clean single-key press, none until full release
  // after a multi-key chord
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
      multi_key_reg <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      multi_key_reg <= (key_class == CLS_MANY);
      case (state_reg)
        ST_IDLE: begin
          if (key_class == CLS_ONE) begin
            key_code_reg  <= bit_to_code(debounced);
            key_valid_reg <= 1'b1;
            key_down_reg  <= 1'b1;
            state_reg     <= ST_PRESSED;
          end else if (key_class == CLS_MANY) begin
            key_down_reg  <= 1'b1;
            state_reg     <= ST_BLOCKED;
          end
        end
        ST_PRESSED: begin
          if (key_class == CLS_NONE) begin
            key_down_reg  <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (key_class == CLS_MANY) begin
            state_reg     <= ST_BLOCKED;
          end
        end
        ST_BLOCKED: begin
          if (key_class == CLS_NONE) begin
            key_down_reg  <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          key_down_reg  <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign kp.col       = col_strobe;
  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_down  = key_down_reg;
  assign kp.multi_key = multi_key_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad model
// and a scoreboard of expected key events.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp_bus ();

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_bus)
  );

  // Keypad model: pressed[4*r+c] pulls row r low while column c is strobed
  logic [15:0] pressed = '0;
  logic        glitch  = 1'b0;

  always_comb begin
    kp_bus.row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r+c] && (kp_bus.col[c] == 1'b0)) kp_bus.row[r] = 1'b0;
      end
    end
    if (glitch) kp_bus.row[0] = 1'b0;
  end

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected event
  always @(negedge clk) begin
    if (kp_bus.key_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_key_valid: got code %0d, want no pulse", kp_bus.key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (kp_bus.key_code !== e) begin
          bad++;
          $display("FAIL key_event_code: got %0d, want %0d", kp_bus.key_code, e);
        end else begin
          $display("key event: code=%0d", kp_bus.key_code);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for all expected events to be consumed, within a cycle budget
  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d pending events, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_col(input logic [3:0] target);
    int t;
    t = 0;
    while (kp_bus.col !== target && t < 32) begin
      @(negedge clk);
      t++;
    end
    check("wait_col", kp_bus.col, target);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        event_exp;
    logic [3:0]  code;
    logic        multi;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic        saw_high;
    logic [3:0]  ecol;
    int          t;

    vecs[0] = '{keys: 16'h0040, event_exp: 1'b1, code: 4'd6,  multi: 1'b0};
    vecs[1] = '{keys: 16'h0001, event_exp: 1'b1, code: 4'd0,  multi: 1'b0};
    vecs[2] = '{keys: 16'h8000, event_exp: 1'b1, code: 4'd15, multi: 1'b0};
    vecs[3] = '{keys: 16'h0200, event_exp: 1'b1, code: 4'd9,  multi: 1'b0};
    vecs[4] = '{keys: 16'h8001, event_exp: 1'b0, code: 4'd9,  multi: 1'b1};

    // Reset and reset values
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    check("reset_col",       kp_bus.col,       COL0);
    check("reset_key_code",  kp_bus.key_code,  4'd0);
    check("reset_key_valid", kp_bus.key_valid, 1'b0);
    check("reset_key_down",  kp_bus.key_down,  1'b0);
    check("reset_multi_key", kp_bus.multi_key, 1'b0);

    // Column rotation every SD cycles
    wait_col(COL1);
    for (int k = 0; k < 8; k++) begin
      ecol = ~(4'b0001 << ((k + 1) % 4));
      check("col_rotation", kp_bus.col, ecol);
      cycles(SD);
    end

    // Idle: no activity on any output for 200 cycles
    saw_high = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kp_bus.key_down !== 1'b0 || kp_bus.multi_key !== 1'b0) saw_high = 1'b1;
    end
    check("idle_quiet", saw_high, 1'b0);

    // Table-driven presses and releases
    for (int v = 0; v < 5; v++) begin
      pressed = vecs[v].keys;
      if (vecs[v].event_exp) exp_q.push_back(vecs[v].code);
      t = 0;
      while (kp_bus.key_down !== 1'b1 && t < 51) begin
        @(negedge clk);
        t++;
      end
      check("press_key_down", kp_bus.key_down, 1'b1);
      cycles(100 - t);
      drain("press_event", 1);
      check("press_multi", kp_bus.multi_key, vecs[v].multi);
      check("press_code", kp_bus.key_code, vecs[v].code);
      pressed = '0;
      cycles(60);
      check("release_key_down", kp_bus.key_down, 1'b0);
      check("release_multi", kp_bus.multi_key, 1'b0);
      check("release_code_held", kp_bus.key_code, vecs[v].code);
    end

    // Bouncy press of key 6 settles into exactly one event
    exp_q.push_back(4'd6);
    for (int i = 0; i < 20; i++) begin
      pressed = ((i / 3) % 2 == 0) ? 16'h0040 : 16'h0000;
      @(negedge clk);
    end
    pressed = 16'h0040;
    cycles(80);
    drain("bounce_event", 1);
    check("bounce_code", kp_bus.key_code, 4'd6);
    pressed = '0;
    cycles(60);
    check("bounce_release", kp_bus.key_down, 1'b0);

    // Chord of keys 0 and 15, partial release, then a clean press of 15
    pressed = 16'h8001;
    cycles(80);
    check("chord_multi", kp_bus.multi_key, 1'b1);
    check("chord_down",  kp_bus.key_down,  1'b1);
    pressed = 16'h0001;
    cycles(60);
    check("chord_partial_multi", kp_bus.multi_key, 1'b0);
    check("chord_partial_down",  kp_bus.key_down,  1'b1);
    pressed = '0;
    cycles(60);
    check("chord_release_down", kp_bus.key_down, 1'b0);
    pressed = 16'h8000;
    exp_q.push_back(4'd15);
    drain("after_chord_event", 60);
    check("after_chord_code", kp_bus.key_code, 4'd15);
    pressed = '0;
    cycles(60);

    // Reset mid-scan while key 3 is held, then re-debounce
    pressed = 16'h0008;
    exp_q.push_back(4'd3);
    drain("pre_reset_event", 60);
    check("pre_reset_code", kp_bus.key_code, 4'd3);
    wait_col(COL1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_col",       kp_bus.col,       COL0);
    check("midreset_key_code",  kp_bus.key_code,  4'd0);
    check("midreset_key_valid", kp_bus.key_valid, 1'b0);
    check("midreset_key_down",  kp_bus.key_down,  1'b0);
    check("midreset_multi_key", kp_bus.multi_key, 1'b0);
    cycles(2);
    exp_q.push_back(4'd3);
    drain("post_reset_event", 70);
    check("post_reset_code", kp_bus.key_code, 4'd3);
    pressed = '0;
    cycles(60);
    check("post_reset_release", kp_bus.key_down, 1'b0);

    // Short glitch on row 0 starting in column 0 never reaches the debounced image
    wait_col(COL0);
    glitch = 1'b1;
    cycles(10);
    glitch = 1'b0;
    saw_high = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (kp_bus.key_down !== 1'b0 || dut.u_debounce.debounced !== 16'h0000) saw_high = 1'b1;
    end
    check("glitch_ignored", saw_high, 1'b0);
    check("glitch_code_held", kp_bus.key_code, 4'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
